ok_insn_bridge: RTL and testbench

OK_INSN_BRIDGE -- requirements
Module: ok_insn_bridge

---
 rtl/ok_insn_bridge.sv | 103 ++++++++++
 tb/tb_ok_insn_bridge.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ok_insn_bridge.sv
// Toggle-handshake instruction bridge: accepts two-half instructions from a
// host toggle protocol into a small FIFO and presents them on a valid/ready port.
module ok_insn_bridge #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       host_req_toggle,
  input  logic [W-1:0]               host_bits_0,
  input  logic [W-1:0]               host_bits_1,
  input  logic                       host_flush,
  output logic                       host_ack_toggle,
  output logic [$clog2(DEPTH):0]     host_level,
  output logic [15:0]                host_fired_count,
  output logic                       insns_valid,
  input  logic                       insns_ready,
  output logic [W-1:0]               insns_bits_0,
  output logic [W-1:0]               insns_bits_1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic           ack_q;
  logic           valid_q;
  logic [15:0]    fired_q;

  logic pending;
  logic full;
  logic push;
  logic pop;

  // Host side: a request is pending while req and ack toggles differ. Full is
  // taken from the registered occupancy, so a same-cycle pop never frees a slot
  // for the push in that cycle.
  // Downstream side: valid/ready. A transfer happens on a rising edge where
  // insns_valid and insns_ready are both 1; valid and data hold until then.
  assign pending = host_req_toggle ^ ack_q;
  assign full    = (count == FULL_LEVEL);
  assign push    = pending & ~full & ~host_flush;
  assign pop     = valid_q & insns_ready & ~host_flush;

  always_comb begin
    count_next = count;
    if (host_flush) begin
      count_next = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      fired_q <= 16'd0;
    end else begin
      count   <= count_next;
      valid_q <= (count_next != '0);
      if (host_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          ack_q  <= ~ack_q;
        end
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          fired_q <= fired_q + 16'd1;
        end
      end
    end
  end

  // Storage carries no reset; only the pointers and occupancy define contents.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {host_bits_1, host_bits_0};
    end
  end

  assign host_ack_toggle  = ack_q;
  assign host_level       = count;
  assign host_fired_count = fired_q;
  assign insns_valid      = valid_q;
  assign insns_bits_0     = mem[rd_ptr][W-1:0];
  assign insns_bits_1     = mem[rd_ptr][2*W-1:W];

endmodule

// File: tb/tb_ok_insn_bridge.sv
// Bench for ok_insn_bridge: queue-based reference model stepped on each edge,
// a negedge monitor comparing every visible output, and directed plus random phases.
module tb_ok_insn_bridge;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic           host_req_toggle;
  logic [W-1:0]   host_bits_0;
  logic [W-1:0]   host_bits_1;
  logic           host_flush;
  logic           host_ack_toggle;
  logic [LW-1:0]  host_level;
  logic [15:0]    host_fired_count;
  logic           insns_valid;
  logic           insns_ready;
  logic [W-1:0]   insns_bits_0;
  logic [W-1:0]   insns_bits_1;

  ok_insn_bridge #(.W(W), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .host_req_toggle  (host_req_toggle),
    .host_bits_0      (host_bits_0),
    .host_bits_1      (host_bits_1),
    .host_flush       (host_flush),
    .host_ack_toggle  (host_ack_toggle),
    .host_level       (host_level),
    .host_fired_count (host_fired_count),
    .insns_valid      (insns_valid),
    .insns_ready      (insns_ready),
    .insns_bits_0     (insns_bits_0),
    .insns_bits_1     (insns_bits_1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic checks_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // reference model: FIFO contents as a queue, plus ack toggle and pop count
  logic [2*W-1:0] exp_q[$];
  logic           m_ack;
  logic [15:0]    m_fired;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_ack   = 1'b0;
      m_fired = 16'd0;
    end else if (host_flush) begin
      exp_q.delete();
    end else begin
      logic was_full;
      logic did_pop;
      was_full = (exp_q.size() == DEPTH);
      did_pop  = (exp_q.size() != 0) && insns_ready;
      if (did_pop) begin
        void'(exp_q.pop_front());
        m_fired = m_fired + 16'd1;
      end
      if ((host_req_toggle != m_ack) && !was_full) begin
        exp_q.push_back({host_bits_1, host_bits_0});
        m_ack = ~m_ack;
      end
    end
  end

  // monitor: compares every output against the model away from the active edge
  always @(negedge clock) begin
    if (checks_en && reset) begin
      check("level", 64'(host_level), 64'(exp_q.size()));
      check("ack",   64'(host_ack_toggle), 64'(m_ack));
      check("valid", 64'(insns_valid), 64'(exp_q.size() != 0));
      check("fired", 64'(host_fired_count), 64'(m_fired));
      if (exp_q.size() != 0)
        check("head", 64'({insns_bits_1, insns_bits_0}), 64'(exp_q[0]));
    end
  end

  // driver: waits (bounded) until no request is outstanding, then raises one
  task automatic issue(input logic [2*W-1:0] d);
    int i;
    i = 0;
    while (host_req_toggle != m_ack && i < 200) begin
      @(negedge clock);
      i++;
    end
    if (host_req_toggle != m_ack) check("issue_wait", 64'd1, 64'd0);
    {host_bits_1, host_bits_0} = d;
    host_req_toggle = ~host_req_toggle;
  endtask

  task automatic drain();
    insns_ready = 1'b1;
    host_flush  = 1'b0;
    repeat (DEPTH + 4) @(negedge clock);
  endtask

  initial begin
    logic [15:0] base;
    logic        saved_ack;
    int          guard;

    reset = 1'b0;
    host_req_toggle = 1'b0;
    host_bits_0 = '0;
    host_bits_1 = '0;
    host_flush  = 1'b0;
    insns_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", 64'(insns_valid), 64'd0);
    check("rst_level", 64'(host_level), 64'd0);
    check("rst_ack",   64'(host_ack_toggle), 64'd0);
    check("rst_fired", 64'(host_fired_count), 64'd0);
    reset = 1'b1;
    checks_en = 1'b1;
    @(negedge clock);

    // single transfer
    insns_ready = 1'b1;
    issue(32'hABCD_1234);
    @(negedge clock);
    check("single_ack",   64'(host_ack_toggle), 64'd1);
    check("single_valid", 64'(insns_valid), 64'd1);
    check("single_bits0", 64'(insns_bits_0), 64'h1234);
    check("single_bits1", 64'(insns_bits_1), 64'hABCD);
    @(negedge clock);
    check("single_fired", 64'(host_fired_count), 64'd1);
    check("single_level", 64'(host_level), 64'd0);
    check("single_idle",  64'(insns_valid), 64'd0);

    // backpressure fill
    insns_ready = 1'b0;
    for (int k = 0; k < 5; k++) issue(32'($urandom));
    @(negedge clock);
    check("bp_level4",    64'(host_level), 64'd4);
    check("bp_withheld",  64'(host_ack_toggle != host_req_toggle), 64'd1);
    insns_ready = 1'b1;
    @(negedge clock);
    insns_ready = 1'b0;
    check("bp_nobypass",  64'(host_level), 64'd3);
    check("bp_still_pend",64'(host_ack_toggle != host_req_toggle), 64'd1);
    @(negedge clock);
    check("bp_accept5",   64'(host_ack_toggle == host_req_toggle), 64'd1);
    check("bp_level_re4", 64'(host_level), 64'd4);
    drain();

    // ordering and pointer wrap
    base = m_fired;
    insns_ready = 1'b1;
    for (int k = 0; k < 10; k++) issue(32'(k));
    drain();
    check("wrap_fired", 64'(host_fired_count), 64'(base + 16'd10));

    // flush with a request pending
    insns_ready = 1'b0;
    for (int k = 0; k < 3; k++) issue(32'h5A00_0000 | 32'(k));
    @(negedge clock);
    check("fl_level3", 64'(host_level), 64'd3);
    saved_ack = m_ack;
    {host_bits_1, host_bits_0} = 32'hF1F1_0E0E;
    host_req_toggle = ~host_req_toggle;
    host_flush = 1'b1;
    @(negedge clock);
    host_flush = 1'b0;
    check("fl_level0", 64'(host_level), 64'd0);
    check("fl_valid0", 64'(insns_valid), 64'd0);
    check("fl_ackhold", 64'(host_ack_toggle), 64'(saved_ack));
    @(negedge clock);
    check("fl_accept", 64'(host_level), 64'd1);
    check("fl_data",   64'({insns_bits_1, insns_bits_0}), 64'h0000_0000_F1F1_0E0E);
    drain();

    // randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      insns_ready = 1'($urandom_range(0, 1));
      host_flush  = ($urandom_range(0, 24) == 0);
      if (host_req_toggle == m_ack && $urandom_range(0, 2) != 0) begin
        {host_bits_1, host_bits_0} = 32'($urandom);
        host_req_toggle = ~host_req_toggle;
      end
      @(negedge clock);
    end
    drain();

    // fired-count wrap: stream one instruction per cycle until 0xFFFF
    insns_ready = 1'b1;
    guard = 0;
    while (m_fired != 16'hFFFF && guard < 70000) begin
      if (host_req_toggle == m_ack) begin
        {host_bits_1, host_bits_0} = 32'($urandom);
        host_req_toggle = ~host_req_toggle;
      end
      @(negedge clock);
      guard++;
    end
    if (m_fired != 16'hFFFF) check("cnt_reach", 64'(m_fired), 64'hFFFF);
    check("cnt_ffff", 64'(host_fired_count), 64'hFFFF);
    guard = 0;
    while (m_fired != 16'h0000 && guard < 20) begin
      if (host_req_toggle == m_ack) begin
        {host_bits_1, host_bits_0} = 32'($urandom);
        host_req_toggle = ~host_req_toggle;
      end
      @(negedge clock);
      guard++;
    end
    check("cnt_wrap0", 64'(host_fired_count), 64'h0000);
    drain();

    // asynchronous reset mid-stream, request held high across release
    insns_ready = 1'b0;
    for (int k = 0; k < 2; k++) issue(32'hC0DE_0000 | 32'(k));
    @(negedge clock);
    check("ar_level2", 64'(host_level), 64'd2);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid0", 64'(insns_valid), 64'd0);
    check("ar_level0", 64'(host_level), 64'd0);
    check("ar_ack0",   64'(host_ack_toggle), 64'd0);
    check("ar_fired0", 64'(host_fired_count), 64'd0);
    host_req_toggle = 1'b1;
    {host_bits_1, host_bits_0} = 32'h7777_1111;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("ar_first_ack",  64'(host_ack_toggle), 64'd1);
    check("ar_first_lvl",  64'(host_level), 64'd1);
    check("ar_first_data", 64'({insns_bits_1, insns_bits_0}), 64'h0000_0000_7777_1111);
    drain();
    check("ar_empty", 64'(insns_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
